// File: rtl/instr_exec_engine.sv
// instr_exec_engine: walks instr_register, executes each word, streams results.
// Ports: start/first_addr/count launch a run; read_pointer/iw_* read the store;
// result_* stream with valid/ready; div_zero/illegal_opc per-beat flags; busy, done.
module instr_exec_engine #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int OPC_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W:0]     count,
  output logic [ADDR_W-1:0]   read_pointer,
  input  logic [OPC_W-1:0]    iw_opc,
  input  logic [OP_W-1:0]     iw_op_a,
  input  logic [OP_W-1:0]     iw_op_b,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [2*OP_W-1:0]   result,
  output logic [ADDR_W-1:0]   result_addr,
  output logic [OPC_W-1:0]    result_opc,
  output logic                div_zero,
  output logic                illegal_opc,
  output logic                busy,
  output logic                done
);

  localparam int RW = 2 * OP_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    OUT,
    FIN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              hs;
  logic              go;

  logic signed [RW-1:0] a_x;
  logic signed [RW-1:0] b_x;
  logic signed [RW-1:0] alu;
  logic                 alu_dz;
  logic                 alu_ill;

  assign hs           = (state == OUT) && result_ready;
  assign go           = (state == IDLE) && start;
  assign result_valid = (state == OUT);
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = (count != '0) ? FETCH : FIN;
      FETCH: state_n = EXEC;
      EXEC:  state_n = OUT;
      OUT:
        if (result_ready)
          state_n = (remaining > (ADDR_W+1)'(1)) ? FETCH : FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands widen to the result width so MULT yields the full product
  // and INT_MIN / -1 cannot overflow.
  always_comb begin
    a_x     = RW'($signed(iw_op_a));
    b_x     = RW'($signed(iw_op_b));
    alu     = '0;
    alu_dz  = 1'b0;
    alu_ill = 1'b0;
    case (iw_opc)
      OPC_W'(0): alu = '0;
      OPC_W'(1): alu = a_x;
      OPC_W'(2): alu = b_x;
      OPC_W'(3): alu = a_x + b_x;
      OPC_W'(4): alu = a_x - b_x;
      OPC_W'(5): alu = a_x * b_x;
      OPC_W'(6):
        if (b_x == '0) alu_dz = 1'b1;
        else           alu = a_x / b_x;
      OPC_W'(7):
        if (b_x == '0) alu_dz = 1'b1;
        else           alu = a_x % b_x;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr         <= '0;
      remaining    <= '0;
      read_pointer <= '0;
      result       <= '0;
      result_addr  <= '0;
      result_opc   <= '0;
      div_zero     <= 1'b0;
      illegal_opc  <= 1'b0;
    end else begin
      if (go && count != '0) begin
        addr      <= first_addr;
        remaining <= count;
      end
      if (state == FETCH) read_pointer <= addr;
      if (state == EXEC) begin
        result      <= alu;
        result_addr <= read_pointer;
        result_opc  <= iw_opc;
        div_zero    <= alu_dz;
        illegal_opc <= alu_ill;
      end
      if (hs) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule
